regfile: RTL and testbench
==========================

# regfile

General-purpose register file for the five-stage pipeline: 31 writable 32-bit registers plus hardwired `$0`, two combinational read ports feeding the ID stage and one write port driven by the MEM/WB register (`wd`/`wreg`/`wdata` produced by the MEM stage). Storage is a RAM-inferable array that is not cleared by reset. A post-reset scrub sequencer therefore zeroes entries 1..31, one per cycle, and holds the pipeline with `stallreq` until done.

## Interface
Parameters:
- `ADDR_W`, 5: register address width; entries = 2^ADDR_W.
- `DATA_W`, 32: register data width.

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset; synchronous, active-low (asserted = 0).
- `we` input 1: write enable from MEM/WB.
- `waddr` input ADDR_W: write register index.
- `wdata` input DATA_W: write data.
- `re1` input 1: read port 1 enable.
- `raddr1` input ADDR_W: read port 1 index.
- `rdata1` output DATA_W: read port 1 data, combinational.
- `re2` input 1: read port 2 enable.
- `raddr2` input ADDR_W: read port 2 index.
- `rdata2` output DATA_W: read port 2 data, combinational.
- `stallreq` output 1: 1 while scrubbing; the controller stalls the whole pipeline.

## Operation
- States: `INIT` (scrubbing), `RUN`.
- Reset (`rst`=0 at a rising edge): next state `INIT`, scrub counter `scnt`=1; the array is not touched.
- `INIT`, `rst`=1: each edge writes 0 to `reg[scnt]` and increments `scnt`. The edge that writes `scnt`=2^ADDR_W−1 moves to `RUN`. External writes are ignored in `INIT`.
- `RUN`: on a rising edge with `we`=1 and `waddr`≠0, `reg[waddr]` ← `wdata`. A write to `waddr`=0 is discarded.
- Read port n (evaluated identically and independently for ports 1 and 2), in priority order:
  - `rst`=0 → 0
  - state `INIT` → 0
  - `ren`=0 → 0
  - `raddrn`=0 → 0
  - bypass hit (see Configuration) → `wdata`
  - otherwise → `reg[raddrn]`
- `stallreq` = 1 when `rst`=0 or state = `INIT`; otherwise 0.
- Both read ports may address the same register; each returns the same value.

## Timing
- Reset values: `stallreq`=1; `rdata1`=`rdata2`=0; state `INIT`; `scnt`=1.
- Scrub length: exactly 2^ADDR_W−1 = 31 rising edges with `rst`=1. `stallreq` falls combinationally after the 31st such edge.
- Reads have zero latency (combinational from the address and enable inputs).
- Write latency is one edge: the value is visible via the array on the cycle after the write edge.
- `rst`=0 during `INIT` or `RUN`: the sequencer restarts from `scnt`=1. Registers already written keep their data but are rescrubbed.
- A write presented on the same edge as the `INIT`→`RUN` transition is ignored.

## Configuration
- `REGFILE_BYPASS_EN` defined: in `RUN`, when `we`=1, `waddr`≠0, `ren`=1 and `raddrn`=`waddr`, `rdatan`=`wdata` in the same cycle (write-before-read). This resolves the ID-vs-WB hazard.
- Not defined: reads always return the array contents, i.e. the old value until the write edge. The ID stage must then stall one cycle on a WB-distance hazard.

## Test plan
- Hold `rst`=0 for 3 cycles, then release: `stallreq`=1 for exactly 31 edges, then 0. Reading every index 1..31 returns 0x00000000.
- In `RUN`, write 0xDEADBEEF to r5, then read r5 on port 1 and port 2 the next cycle: both return 0xDEADBEEF. Writing 0x12345678 to r0 leaves r0 reading 0.
- Write r7=0xA5A5A5A5 while `raddr1`=7, `re1`=1 in the same cycle: 0xA5A5A5A5 with `REGFILE_BYPASS_EN`, previous value (0) without.
- `re1`=0 with `raddr1`=5 (r5=0xDEADBEEF): `rdata1`=0. `re2`=1 on the same index still returns 0xDEADBEEF.
- Pulse `rst`=0 for one edge after r5=0xDEADBEEF, mid-`RUN`: `stallreq`=1 for 31 more edges, after which r5 reads 0.
- Assert `we`=1, `waddr`=3, `wdata`=0x1 during `INIT`: after scrub, r3 reads 0.

Source files
------------

// File: rtl/regfile.sv
// Two-read / one-write register file with hardwired $0 and a post-reset scrub.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              stallreq
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] scnt_q;
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Scrub sequencer: walks 1..DEPTH-1, then hands over to RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= INIT;
            scnt_q  <= ADDR_W'(1);
        end else if (state_q == INIT) begin
            scnt_q <= scnt_q + ADDR_W'(1);
            if (scnt_q == {ADDR_W{1'b1}}) begin
                state_q <= RUN;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (rst) begin
            if (state_q == INIT) begin
                mem_we    = 1'b1;
                mem_waddr = scnt_q;
                mem_wdata = '0;
            end else if (we && waddr != '0) begin
                mem_we = 1'b1;
            end
        end
    end

    // Storage deliberately has no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(
        input logic              ren,
        input logic [ADDR_W-1:0] ra
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (!rst || state_q == INIT) begin
            v = '0;
        end else if (!ren || ra == '0) begin
            v = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (we && waddr != '0 && ra == waddr) begin
            v = wdata;
`endif
        end else begin
            v = mem_q[ra];
        end
        return v;
    endfunction

    always_comb begin
        rdata1 = rd_port(re1, raddr1);
    end

    always_comb begin
        rdata2 = rd_port(re2, raddr2);
    end

    assign stallreq = !rst || (state_q == INIT);

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: vector table, corner sequences and
// randomized traffic against a behavioural register-array model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        stallreq;

    regfile #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re1     (re1),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .re2     (re2),
        .raddr2  (raddr2),
        .rdata2  (rdata2),
        .stallreq(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: register contents plus number of scrub edges left
    logic [31:0] m [32];
    int          left = 31;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic ren, input logic [4:0] ra);
        if (!rst || left > 0) return 32'h0;
        if (!ren || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr != 5'd0 && ra == waddr) return wdata;
`endif
        return m[ra];
    endfunction

    task automatic m_edge();
        if (!rst) begin
            left = 31;
        end else if (left > 0) begin
            m[32 - left] = 32'h0;
            left--;
        end else if (we && waddr != 5'd0) begin
            m[waddr] = wdata;
        end
    endtask

    // Check outputs against the model, then take one clock edge
    task automatic cyc(input string tag);
        #1;
        chk({tag, ".rd1"}, rdata1, m_rd(re1, raddr1));
        chk({tag, ".rd2"}, rdata2, m_rd(re2, raddr2));
        chk({tag, ".stall"}, {31'h0, stallreq},
            {31'h0, (!rst || left > 0)});
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0;
        re2 = 1'b0; raddr2 = 5'd0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        r1;
        logic [4:0]  a1;
        logic        r2;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic [31:0] byp7;
`ifdef REGFILE_BYPASS_EN
        byp7 = 32'hA5A5_A5A5;
`else
        byp7 = 32'h0;
`endif
        vt[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0};
        vt[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[2] = '{1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0};
        vt[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0};
        vt[4] = '{1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd5, byp7, 32'hDEAD_BEEF};
        vt[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vt[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5, 32'h0, 32'hDEAD_BEEF};

        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        idle();
        rst = 1'b0;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst.stall", {31'h0, stallreq}, 32'h1);
            chk("rst.rd1", rdata1, 32'h0);
            cyc("rst");
        end

        // Scrub: exactly 31 stalled edges
        rst = 1'b1;
        for (int i = 0; i < 31; i++) begin
            #1;
            chk($sformatf("scrub%0d.stall", i), {31'h0, stallreq}, 32'h1);
            cyc("scrub");
        end
        #1;
        chk("scrub.done", {31'h0, stallreq}, 32'h0);

        for (int i = 1; i < 32; i++) begin
            re1 = 1'b1; raddr1 = 5'(i);
            re2 = 1'b1; raddr2 = 5'(32 - i);
            #1;
            chk($sformatf("zero.r%0d", i), rdata1, 32'h0);
            chk($sformatf("zero.r%0d", 32 - i), rdata2, 32'h0);
            cyc("zero");
        end

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
            re1 = vt[i].r1; raddr1 = vt[i].a1;
            re2 = vt[i].r2; raddr2 = vt[i].a2;
            #1;
            chk($sformatf("vec%0d.rd1", i), rdata1, vt[i].e1);
            chk($sformatf("vec%0d.rd2", i), rdata2, vt[i].e2);
            cyc($sformatf("vec%0d", i));
        end

        // Mid-RUN reset pulse, with writes presented throughout INIT
        idle();
        rst = 1'b0;
        cyc("pulse");
        rst = 1'b1;
        for (int i = 0; i < 31; i++) begin
            we = 1'b1;
            waddr = (i == 30) ? 5'd9 : 5'd3;
            wdata = (i == 30) ? 32'h0000_00FF : 32'h1;
            #1;
            chk($sformatf("rescrub%0d.stall", i), {31'h0, stallreq}, 32'h1);
            cyc("rescrub");
        end
        idle();
        #1;
        chk("rescrub.done", {31'h0, stallreq}, 32'h0);
        re1 = 1'b1; raddr1 = 5'd5;
        re2 = 1'b1; raddr2 = 5'd3;
        #1;
        chk("rescrub.r5", rdata1, 32'h0);
        chk("initwr.r3", rdata2, 32'h0);
        cyc("rescrub.rd");
        raddr1 = 5'd9; raddr2 = 5'd9;
        #1;
        chk("lastedge.r9", rdata1, 32'h0);
        cyc("lastedge.rd");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) != 0);
            we = $urandom_range(0, 1) == 1;
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            re1 = $urandom_range(0, 7) != 0;
            re2 = $urandom_range(0, 7) != 0;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
